reg_file_param: RTL and testbench

- Parametrised successor to the 4x8 accumulator register file: configurable data width and register count, two registered read ports, one write port.
- Separate read and write enables, so reads and writes can happen in the same cycle.
- Hardwired zero register and a per-register busy scoreboard used by the datapath for hazard checks.
- Sits between the decode stage (read addresses, reservations) and the accumulator/ALU writeback.

---
 rtl/rf_pkg.sv | 27 ++
 rtl/rf_scoreboard.sv | 46 ++++
 rtl/reg_file_param.sv | 120 ++++++++++++
 tb/tb_reg_file_param.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants for the parametrised register file: default sizes,
// reset contents of the low registers and a clog2 helper.
package rf_pkg;

    localparam int RF_DATA_W   = 8;
    localparam int RF_NUM_REGS = 4;

    localparam logic [7:0] INIT_TABLE [4] = '{8'd1, 8'd2, 8'd3, 8'd5};

    function automatic int rf_clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Registers beyond the table come out of reset as zero.
    function automatic logic [7:0] rf_init_val(input int unsigned idx);
        if (idx < 4) begin
            return INIT_TABLE[idx[1:0]];
        end
        return '0;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: reservations set, writebacks clear,
// a same-cycle reservation beats the writeback on the same register.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ZERO_REG = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rsv_en,
    input  logic [rf_clog2(NUM_REGS)-1:0] rsv_addr,
    input  logic                          wr_en,
    input  logic [rf_clog2(NUM_REGS)-1:0] wr_addr,
    output logic [NUM_REGS-1:0]           busy_vec,
    output logic [NUM_REGS-1:0]           busy_nxt
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_en) begin
            busy_d[rsv_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;
    assign busy_nxt = busy_d;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: two registered read ports, one write port,
// optional zero register and busy scoreboard. Define RF_BYPASS_EN for write-to-read bypass.
module reg_file_param
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ZERO_REG = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rd_en,
    input  logic [rf_clog2(NUM_REGS)-1:0] rd_addr1,
    input  logic [rf_clog2(NUM_REGS)-1:0] rd_addr2,
    output logic [DATA_W-1:0]             rd_data1,
    output logic [DATA_W-1:0]             rd_data2,
    output logic                          rd_valid,
    output logic                          rd_busy1,
    output logic                          rd_busy2,
    input  logic                          wr_en,
    input  logic [rf_clog2(NUM_REGS)-1:0] wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          rsv_en,
    input  logic [rf_clog2(NUM_REGS)-1:0] rsv_addr,
    output logic [NUM_REGS-1:0]           busy_vec
);

    localparam int ADDR_W = rf_clog2(NUM_REGS);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] rd_data1_q, rd_data2_q;
    logic              rd_busy1_q, rd_busy2_q, rd_valid_q;
    logic [DATA_W-1:0] rd_data1_d, rd_data2_d;
    logic              rd_busy1_d, rd_busy2_d;
    logic              wr_ok;
`ifdef RF_BYPASS_EN
    logic [NUM_REGS-1:0] busy_nxt;
`endif

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .busy_vec (busy_vec),
`ifdef RF_BYPASS_EN
        .busy_nxt (busy_nxt)
`else
        .busy_nxt ()
`endif
    );

    assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    always_comb begin
        rd_data1_d = regs_q[rd_addr1];
        rd_data2_d = regs_q[rd_addr2];
        rd_busy1_d = busy_vec[rd_addr1];
        rd_busy2_d = busy_vec[rd_addr2];
`ifdef RF_BYPASS_EN
        // Bypassed reads see the post-edge scoreboard, so a same-cycle reservation still shows busy.
        if (wr_en && (wr_addr == rd_addr1)) begin
            rd_data1_d = wr_data;
            rd_busy1_d = busy_nxt[rd_addr1];
        end
        if (wr_en && (wr_addr == rd_addr2)) begin
            rd_data2_d = wr_data;
            rd_busy2_d = busy_nxt[rd_addr2];
        end
`endif
        if ((ZERO_REG != 0) && (rd_addr1 == '0)) begin
            rd_data1_d = '0;
            rd_busy1_d = 1'b0;
        end
        if ((ZERO_REG != 0) && (rd_addr2 == '0)) begin
            rd_data2_d = '0;
            rd_busy2_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= DATA_W'(rf_init_val(k));
            end
        end else if (wr_ok) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data1_q <= '0;
            rd_data2_q <= '0;
            rd_busy1_q <= 1'b0;
            rd_busy2_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data1_q <= rd_data1_d;
                rd_data2_q <= rd_data2_d;
                rd_busy1_q <= rd_busy1_d;
                rd_busy2_q <= rd_busy2_d;
            end
        end
    end

    assign rd_data1 = rd_data1_q;
    assign rd_data2 = rd_data2_q;
    assign rd_busy1 = rd_busy1_q;
    assign rd_busy2 = rd_busy2_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: default 8x4 instance and a 16x16 instance,
// directed scenarios plus randomized traffic against an array-based model.
module tb_reg_file_param;

    logic clk;
    logic reset;

    logic        re [2];
    logic        we [2];
    logic        rv [2];
    logic [3:0]  a1 [2];
    logic [3:0]  a2 [2];
    logic [3:0]  wa [2];
    logic [3:0]  rsa [2];
    logic [15:0] wd [2];

    logic [7:0]  o0_rd1, o0_rd2;
    logic        o0_v, o0_b1, o0_b2;
    logic [3:0]  o0_bv;
    logic [15:0] o1_rd1, o1_rd2;
    logic        o1_v, o1_b1, o1_b2;
    logic [15:0] o1_bv;

    logic [15:0] m_regs [2][16];
    logic        m_busy [2][16];
    logic [15:0] e_rd1 [2];
    logic [15:0] e_rd2 [2];
    logic        e_b1 [2];
    logic        e_b2 [2];
    logic        e_v [2];
    logic [15:0] e_bv [2];

    int n_total;
    int n_bad;

    reg_file_param u_dut0 (
        .clk (clk), .reset (reset), .rd_en (re[0]),
        .rd_addr1 (a1[0][1:0]), .rd_addr2 (a2[0][1:0]),
        .rd_data1 (o0_rd1), .rd_data2 (o0_rd2), .rd_valid (o0_v),
        .rd_busy1 (o0_b1), .rd_busy2 (o0_b2),
        .wr_en (we[0]), .wr_addr (wa[0][1:0]), .wr_data (wd[0][7:0]),
        .rsv_en (rv[0]), .rsv_addr (rsa[0][1:0]), .busy_vec (o0_bv)
    );

    reg_file_param #(.DATA_W (16), .NUM_REGS (16), .ZERO_REG (1)) u_dut1 (
        .clk (clk), .reset (reset), .rd_en (re[1]),
        .rd_addr1 (a1[1]), .rd_addr2 (a2[1]),
        .rd_data1 (o1_rd1), .rd_data2 (o1_rd2), .rd_valid (o1_v),
        .rd_busy1 (o1_b1), .rd_busy2 (o1_b2),
        .wr_en (we[1]), .wr_addr (wa[1]), .wr_data (wd[1]),
        .rsv_en (rv[1]), .rsv_addr (rsa[1]), .busy_vec (o1_bv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int nregs(input int d);
        return (d == 0) ? 4 : 16;
    endfunction

    function automatic logic [15:0] dmask(input int d);
        return (d == 0) ? 16'h00FF : 16'hFFFF;
    endfunction

    task automatic model_reset();
        logic [15:0] init [4];
        init = '{16'd1, 16'd2, 16'd3, 16'd5};
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 16; k++) begin
                m_regs[d][k] = (k < 4) ? init[k] : 16'h0;
                m_busy[d][k] = 1'b0;
            end
            e_rd1[d] = '0; e_rd2[d] = '0;
            e_b1[d] = 1'b0; e_b2[d] = 1'b0; e_v[d] = 1'b0; e_bv[d] = '0;
        end
    endtask

    // What a read of address a sees this cycle, taking the same-cycle write into account.
    task automatic peek(input int d, input logic [3:0] a, output logic [15:0] data, output logic busy);
        if (a == 0) begin
            data = '0; busy = 1'b0;
        end
`ifdef RF_BYPASS_EN
        else if (we[d] && wa[d] == a) begin
            data = wd[d] & dmask(d);
            busy = rv[d] && (rsa[d] == a);
        end
`endif
        else begin
            data = m_regs[d][a];
            busy = m_busy[d][a];
        end
    endtask

    task automatic model_step(input int d);
        logic [15:0] dat;
        logic        bsy;
        if (re[d]) begin
            peek(d, a1[d], dat, bsy); e_rd1[d] = dat; e_b1[d] = bsy;
            peek(d, a2[d], dat, bsy); e_rd2[d] = dat; e_b2[d] = bsy;
        end
        e_v[d] = re[d];
        if (we[d] && wa[d] != 0) m_regs[d][wa[d]] = wd[d] & dmask(d);
        if (we[d]) m_busy[d][wa[d]] = 1'b0;
        if (rv[d]) m_busy[d][rsa[d]] = 1'b1;
        m_busy[d][0] = 1'b0;
        e_bv[d] = '0;
        for (int k = 0; k < nregs(d); k++) e_bv[d][k] = m_busy[d][k];
    endtask

    task automatic check_outputs(input string ph);
        check_val({ph, "_v0"},   32'(o0_v),   32'(e_v[0]));
        check_val({ph, "_rd1_0"}, 32'(o0_rd1), 32'(e_rd1[0]));
        check_val({ph, "_rd2_0"}, 32'(o0_rd2), 32'(e_rd2[0]));
        check_val({ph, "_b1_0"}, 32'(o0_b1),  32'(e_b1[0]));
        check_val({ph, "_b2_0"}, 32'(o0_b2),  32'(e_b2[0]));
        check_val({ph, "_bv0"},  32'(o0_bv),  32'(e_bv[0]));
        check_val({ph, "_v1"},   32'(o1_v),   32'(e_v[1]));
        check_val({ph, "_rd1_1"}, 32'(o1_rd1), 32'(e_rd1[1]));
        check_val({ph, "_rd2_1"}, 32'(o1_rd2), 32'(e_rd2[1]));
        check_val({ph, "_b1_1"}, 32'(o1_b1),  32'(e_b1[1]));
        check_val({ph, "_b2_1"}, 32'(o1_b2),  32'(e_b2[1]));
        check_val({ph, "_bv1"},  32'(o1_bv),  32'(e_bv[1]));
    endtask

    task automatic set_in(input int d, input logic r_en, input logic [3:0] r1, input logic [3:0] r2,
                          input logic w_en, input logic [3:0] w_a, input logic [15:0] w_d,
                          input logic s_en, input logic [3:0] s_a);
        re[d] = r_en; a1[d] = r1; a2[d] = r2;
        we[d] = w_en; wa[d] = w_a; wd[d] = w_d;
        rv[d] = s_en; rsa[d] = s_a;
    endtask

    task automatic idle();
        for (int d = 0; d < 2; d++) set_in(d, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cycle(input string ph);
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_outputs(ph);
    endtask

    initial begin
        logic [7:0] exp_p3;
        n_total = 0;
        n_bad = 0;
        reset = 1'b0;
        idle();
        model_reset();
        #1;
        check_outputs("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Reset contents through both ports, zero register masked
        idle(); set_in(0, 1, 1, 2, 0, 0, 0, 0, 0); cycle("p1a");
        check_val("p1_rd_1", 32'(o0_rd1), 32'h2);
        check_val("p1_rd_2", 32'(o0_rd2), 32'h3);
        idle(); set_in(0, 1, 3, 0, 0, 0, 0, 0, 0); cycle("p1b");
        check_val("p1_rd_3", 32'(o0_rd1), 32'h5);
        check_val("p1_rd_0", 32'(o0_rd2), 32'h0);
        idle(); cycle("p1c");
        check_val("p1_valid_drop", 32'(o0_v), 32'h0);

        // Plain write then read; zero register ignores writes
        idle(); set_in(0, 0, 0, 0, 1, 2, 16'hA5, 0, 0); cycle("p2a");
        idle(); set_in(0, 1, 2, 2, 0, 0, 0, 0, 0); cycle("p2b");
        check_val("p2_rd_a5", 32'(o0_rd1), 32'hA5);
        idle(); set_in(0, 0, 0, 0, 1, 0, 16'hFF, 0, 0); cycle("p2c");
        idle(); set_in(0, 1, 0, 0, 0, 0, 0, 0, 0); cycle("p2d");
        check_val("p2_rd_zero", 32'(o0_rd1), 32'h0);

        // Same-cycle write and read of one register
`ifdef RF_BYPASS_EN
        exp_p3 = 8'h3C;
`else
        exp_p3 = 8'h05;
`endif
        idle(); set_in(0, 1, 3, 3, 1, 3, 16'h3C, 0, 0); cycle("p3");
        check_val("p3_same_cycle", 32'(o0_rd1), 32'(exp_p3));

        // Scoreboard set, observe, clear, and reservation-wins collision
        idle(); set_in(0, 0, 0, 0, 0, 0, 0, 1, 1); cycle("p4a");
        check_val("p4_bv_rsv1", 32'(o0_bv), 32'h2);
        idle(); set_in(0, 1, 1, 2, 0, 0, 0, 0, 0); cycle("p4b");
        check_val("p4_busy1", 32'(o0_b1), 32'h1);
        idle(); set_in(0, 0, 0, 0, 1, 1, 16'h11, 0, 0); cycle("p4c");
        check_val("p4_bv_clr", 32'(o0_bv), 32'h0);
        idle(); set_in(0, 0, 0, 0, 1, 2, 16'h22, 1, 2); cycle("p4d");
        check_val("p4_bv_collide", 32'(o0_bv), 32'h4);

        // Reset arriving while a read result is still being presented
        idle(); set_in(0, 1, 1, 2, 0, 0, 0, 0, 0); set_in(1, 0, 0, 0, 0, 0, 0, 1, 7); cycle("p5a");
        reset = 1'b0;
        #1;
        check_val("p5_valid", 32'(o0_v), 32'h0);
        check_val("p5_rd1", 32'(o0_rd1), 32'h0);
        check_val("p5_bv0", 32'(o0_bv), 32'h0);
        check_val("p5_bv1", 32'(o1_bv), 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        idle(); set_in(0, 1, 2, 3, 0, 0, 0, 0, 0); cycle("p5b");
        check_val("p5_reinit_2", 32'(o0_rd1), 32'h3);
        check_val("p5_reinit_3", 32'(o0_rd2), 32'h5);

        // Wide instance: upper registers clear after reset, full-width data path
        for (int k = 4; k < 16; k++) begin
            idle(); set_in(1, 1, 4'(k), 4'(k), 0, 0, 0, 0, 0); cycle("p6a");
            check_val($sformatf("p6_hi_reg%0d", k), 32'(o1_rd1), 32'h0);
        end
        idle(); set_in(1, 0, 0, 0, 1, 15, 16'hBEEF, 0, 0); cycle("p6b");
        idle(); set_in(1, 1, 15, 15, 0, 0, 0, 0, 0); cycle("p6c");
        check_val("p6_beef_1", 32'(o1_rd1), 32'hBEEF);
        check_val("p6_beef_2", 32'(o1_rd2), 32'hBEEF);

        // Randomized traffic, biased toward address collisions
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 2; d++) begin
                logic [3:0] w_a, r1, r2, s_a;
                int hi;
                hi  = nregs(d) - 1;
                w_a = 4'($urandom_range(0, hi));
                r1  = ($urandom_range(0, 2) == 0) ? w_a : 4'($urandom_range(0, hi));
                r2  = ($urandom_range(0, 2) == 0) ? r1 : 4'($urandom_range(0, hi));
                s_a = ($urandom_range(0, 3) == 0) ? w_a : 4'($urandom_range(0, hi));
                set_in(d, 1'($urandom), r1, r2, 1'($urandom), w_a, 16'($urandom) & dmask(d),
                       1'($urandom), s_a);
            end
            cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
